// File: rtl/alu_word_seq_pkg.sv
// Shared definitions for the word ALU: opcode values, Z8 flag bit indices,
// FSM state encoding and small opcode-classification helpers.
// Optional feature macro: ALU_WORD_SEQ_DA_EN. When it is defined, opcode 19
// is decimal adjust (DA). When it is undefined, opcode 19 is a reserved no-op.
package alu_word_seq_pkg;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_ADC = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_SBC = 5'd3;
  localparam logic [4:0] OP_CP  = 5'd4;
  localparam logic [4:0] OP_AND = 5'd5;
  localparam logic [4:0] OP_OR  = 5'd6;
  localparam logic [4:0] OP_XOR = 5'd7;
  localparam logic [4:0] OP_TM  = 5'd8;
  localparam logic [4:0] OP_TCM = 5'd9;
  localparam logic [4:0] OP_INC = 5'd10;
  localparam logic [4:0] OP_DEC = 5'd11;
  localparam logic [4:0] OP_COM = 5'd12;
  localparam logic [4:0] OP_CLR = 5'd13;
  localparam logic [4:0] OP_RL  = 5'd14;
  localparam logic [4:0] OP_RLC = 5'd15;
  localparam logic [4:0] OP_RR  = 5'd16;
  localparam logic [4:0] OP_RRC = 5'd17;
  localparam logic [4:0] OP_SRA = 5'd18;
  localparam logic [4:0] OP_DA  = 5'd19;

  localparam int FLAG_C = 7;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 5;
  localparam int FLAG_V = 4;
  localparam int FLAG_D = 3;
  localparam int FLAG_H = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right rotates and SRA move bits toward the LSB, so the shift chain has
  // to start at the top byte.
  function automatic logic is_msb_first(input logic [4:0] op);
    return (op == OP_RR) || (op == OP_RRC) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_byte_slice.sv
// One 8-bit slice of the word ALU (purely combinational).
// Ports:
//   i_op   opcode           i_a/i_b  operand bytes     i_cin  carry/borrow/shift-in
//   i_hf/i_cf/i_d  (ALU_WORD_SEQ_DA_EN only) H, C and D as seen by this byte for DA
//   o_val  byte used for Z/S  o_res  byte written to the result word
//   o_cout carry/borrow/shifted-out bit   o_hc  nibble carry/borrow   o_v  sign overflow
module alu_byte_slice
  import alu_word_seq_pkg::*;
(
  input  logic [4:0] i_op,
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
`ifdef ALU_WORD_SEQ_DA_EN
  input  logic       i_hf,
  input  logic       i_cf,
  input  logic       i_d,
`endif
  output logic [7:0] o_val,
  output logic [7:0] o_res,
  output logic       o_cout,
  output logic       o_hc,
  output logic       o_v
);

  logic [8:0] w_add9;
  logic [8:0] w_sub9;
  logic [8:0] w_inc9;
  logic [8:0] w_dec9;
  logic       w_hc_add;
  logic       w_hc_sub;

  assign w_add9   = {1'b0, i_a} + {1'b0, i_b} + {8'd0, i_cin};
  assign w_sub9   = {1'b0, i_a} - {1'b0, i_b} - {8'd0, i_cin};
  assign w_inc9   = {1'b0, i_a} + {8'd0, i_cin};
  assign w_dec9   = {1'b0, i_a} - {8'd0, i_cin};
  assign w_hc_add = ({1'b0, i_a[3:0]} + {1'b0, i_b[3:0]} + {4'd0, i_cin}) >= 5'd16;
  assign w_hc_sub = {1'b0, i_a[3:0]} < ({1'b0, i_b[3:0]} + {4'd0, i_cin});

`ifdef ALU_WORD_SEQ_DA_EN
  logic       w_da_lo;
  logic       w_da_hi;
  logic [7:0] w_da_corr;
  logic [8:0] w_da9;

  // After an add, a nibble also needs correcting when it is >9. After a
  // subtract, only the H and C flags can say whether a borrow left a bad digit.
  assign w_da_lo   = i_d ? i_hf : (i_hf || (i_a[3:0] > 4'd9));
  assign w_da_hi   = i_d ? i_cf : (i_cf || (i_a > 8'h99));
  assign w_da_corr = {(w_da_hi ? 4'h6 : 4'h0), (w_da_lo ? 4'h6 : 4'h0)};
  assign w_da9     = i_d ? ({1'b0, i_a} - {1'b0, w_da_corr} - {8'd0, i_cin})
                         : ({1'b0, i_a} + {1'b0, w_da_corr} + {8'd0, i_cin});
`endif

  always_comb begin
    o_val  = i_a;
    o_cout = i_cin;
    o_hc   = 1'b0;
    o_v    = 1'b0;
    case (i_op)
      OP_ADD, OP_ADC: begin
        o_val  = w_add9[7:0];
        o_cout = w_add9[8];
        o_hc   = w_hc_add;
        o_v    = (i_a[7] == i_b[7]) && (w_add9[7] != i_a[7]);
      end
      OP_SUB, OP_SBC, OP_CP: begin
        o_val  = w_sub9[7:0];
        o_cout = w_sub9[8];
        o_hc   = w_hc_sub;
        o_v    = (i_a[7] != i_b[7]) && (w_sub9[7] != i_a[7]);
      end
      OP_INC: begin
        o_val  = w_inc9[7:0];
        o_cout = w_inc9[8];
        o_v    = !i_a[7] && w_inc9[7];
      end
      OP_DEC: begin
        o_val  = w_dec9[7:0];
        o_cout = w_dec9[8];
        o_v    = i_a[7] && !w_dec9[7];
      end
      OP_AND, OP_TM: o_val = i_a & i_b;
      OP_OR:         o_val = i_a | i_b;
      OP_XOR:        o_val = i_a ^ i_b;
      OP_TCM:        o_val = ~i_a & i_b;
      OP_COM:        o_val = ~i_a;
      OP_CLR:        o_val = 8'h00;
      OP_RL, OP_RLC: begin
        o_val  = {i_a[6:0], i_cin};
        o_cout = i_a[7];
      end
      OP_RR, OP_RRC, OP_SRA: begin
        o_val  = {i_cin, i_a[7:1]};
        o_cout = i_a[0];
      end
`ifdef ALU_WORD_SEQ_DA_EN
      OP_DA: begin
        o_val  = w_da9[7:0];
        o_cout = w_da_hi || w_da9[8];
      end
`endif
      default: o_val = i_a;
    endcase
  end

  // Compare/test ops only report flags; the result word is operand a.
  always_comb begin
    o_res = o_val;
    case (i_op)
      OP_CP, OP_TM, OP_TCM: o_res = i_a;
      default:              o_res = o_val;
    endcase
  end

endmodule

// File: rtl/alu_word_seq.sv
// Multi-cycle word ALU. Processes one BYTES-byte op through a single 8-bit
// slice, one byte per clock, chaining carry, half-carry and zero.
// Optional feature macro: ALU_WORD_SEQ_DA_EN (enables op 19 = DA).
// Ports:
//   clk, reset_n (async, active-low)
//   cmd_valid/cmd_ready, op, a, b, flags_in : command handshake and operands
//   res_valid/res_ready, result, flags_out  : result handshake and outputs
//   busy                                    : high whenever not IDLE
module alu_word_seq
  import alu_word_seq_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [4:0]           op,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  input  logic [7:0]           flags_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [8*BYTES-1:0]   result,
  output logic [7:0]           flags_out,
  output logic                 busy
);

  localparam int W  = 8 * BYTES;
  localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_res;
  logic [7:0]      r_flags;
  logic [4:0]      r_op;
  logic [7:0]      r_fin;
  logic            r_c;
  logic            r_h;
  logic            r_v;
  logic            r_z;
  logic            r_s;
  logic            r_amsb;

  logic            w_accept;
  logic            w_step;
  logic            w_first;
  logic            w_last;
  logic            w_msb;
  logic            w_top;
  logic            w_cin0;
  logic [7:0]      w_abyte;
  logic [7:0]      w_bbyte;
  logic [7:0]      w_val;
  logic [7:0]      w_res_byte;
  logic            w_cout;
  logic            w_hc;
  logic            w_v;
  logic            w_z_fin;
  logic            w_s_fin;
  logic            w_v_fin;
  logic            w_h_fin;

  function automatic logic [7:0] f_flags(input logic [4:0] fop, input logic [7:0] fin,
                                         input logic c, input logic h, input logic v,
                                         input logic z, input logic s, input logic amsb);
    logic [7:0] f;
    f = fin;
    case (fop)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CP: begin
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
        f[FLAG_V] = v;
        f[FLAG_D] = (fop == OP_SUB) || (fop == OP_SBC) || (fop == OP_CP);
        f[FLAG_H] = h;
      end
      OP_AND, OP_OR, OP_XOR, OP_TM, OP_TCM, OP_COM: begin
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
        f[FLAG_V] = 1'b0;
      end
      OP_INC, OP_DEC: begin
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
        f[FLAG_V] = v;
      end
      OP_RL, OP_RLC, OP_RR, OP_RRC, OP_SRA: begin
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
        f[FLAG_V] = s ^ amsb;
      end
`ifdef ALU_WORD_SEQ_DA_EN
      OP_DA: begin
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_S] = s;
      end
`endif
      default: f = fin;
    endcase
    return f;
  endfunction

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign res_valid = (r_state == ST_DONE);
  assign result    = r_res;
  assign flags_out = r_flags;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);
  assign w_step   = (r_state == ST_RUN);
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LAST);
  assign w_msb    = is_msb_first(r_op);
  assign w_top    = w_msb ? w_first : w_last;
  assign w_abyte  = w_msb ? r_a[W-1 -: 8] : r_a[7:0];
  assign w_bbyte  = w_msb ? r_b[W-1 -: 8] : r_b[7:0];

  // Carry/shift-in for the first byte; later bytes take the chained carry.
  always_comb begin
    w_cin0 = 1'b0;
    case (op)
      OP_ADC, OP_SBC, OP_RLC, OP_RRC: w_cin0 = flags_in[FLAG_C];
      OP_INC, OP_DEC:                 w_cin0 = 1'b1;
      OP_RL, OP_SRA:                  w_cin0 = a[W-1];
      OP_RR:                          w_cin0 = a[0];
      default:                        w_cin0 = 1'b0;
    endcase
  end

  alu_byte_slice u_slice (
    .i_op   (r_op),
    .i_a    (w_abyte),
    .i_b    (w_bbyte),
    .i_cin  (r_c),
`ifdef ALU_WORD_SEQ_DA_EN
    .i_hf   (w_first && r_fin[FLAG_H]),
    .i_cf   (w_top && r_fin[FLAG_C]),
    .i_d    (r_fin[FLAG_D]),
`endif
    .o_val  (w_val),
    .o_res  (w_res_byte),
    .o_cout (w_cout),
    .o_hc   (w_hc),
    .o_v    (w_v)
  );

  assign w_z_fin = r_z && (w_val == 8'h00);
  assign w_s_fin = w_top ? w_val[7] : r_s;
  assign w_v_fin = w_top ? w_v : r_v;
  assign w_h_fin = w_first ? w_hc : r_h;

  // FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (cmd_valid) w_next = ST_RUN;
      ST_RUN:  if (w_last)    w_next = ST_DONE;
      ST_DONE: if (res_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte counter and the visible result/flag registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_res   <= '0;
      r_flags <= 8'h00;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      // Result bytes enter at the end opposite to the processing order, so
      // after BYTES steps every byte sits at its own position.
      if (w_msb) r_res <= (r_res << 8) | W'(w_res_byte);
      else       r_res <= (r_res >> 8) | (W'(w_res_byte) << (W - 8));
      if (w_last)
        r_flags <= f_flags(r_op, r_fin, w_cout, w_h_fin, w_v_fin, w_z_fin, w_s_fin, r_amsb);
    end
  end

  // Latched operands and the running carry/flag state
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a    <= a;
      r_b    <= b;
      r_op   <= op;
      r_fin  <= flags_in;
      r_c    <= w_cin0;
      r_z    <= 1'b1;
      r_amsb <= a[W-1];
    end else if (w_step) begin
      if (w_msb) begin
        r_a <= r_a << 8;
        r_b <= r_b << 8;
      end else begin
        r_a <= r_a >> 8;
        r_b <= r_b >> 8;
      end
      r_c <= w_cout;
      r_z <= w_z_fin;
      r_s <= w_s_fin;
      r_v <= w_v_fin;
      r_h <= w_h_fin;
    end
  end

endmodule

// File: tb/tb_alu_word_seq.sv
module tb_alu_word_seq;
  import alu_word_seq_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [7:0]  flags_in;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;
  logic [7:0]  flags_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_word_seq #(.BYTES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flags_in  (flags_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result),
    .flags_out (flags_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic [7:0] f);
    @(negedge clk);
    cmd_valid = 1'b1;
    op        = o;
    a         = va;
    b         = vb;
    flags_in  = f;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    op        = 5'($urandom);
    a         = 16'($urandom);
    b         = 16'($urandom);
    flags_in  = 8'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [4:0] o, input logic [15:0] va,
                        input logic [15:0] vb, input logic [7:0] f,
                        input logic [15:0] exp_res, input logic [7:0] exp_flags);
    int lat;
    issue(o, va, vb, f);
    lat = 0;
    while (!res_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " result"}, result, exp_res);
    check({tag, " flags"}, flags_out, exp_flags);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check({tag, " idle res_valid"}, res_valid, 1'b0);
    check({tag, " idle cmd_ready"}, cmd_ready, 1'b1);
  endtask

  initial begin
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    op        = 5'd0;
    a         = 16'h0;
    b         = 16'h0;
    flags_in  = 8'h0;
    repeat (3) @(negedge clk);
    check("rst cmd_ready", cmd_ready, 1'b1);
    check("rst res_valid", res_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst result", result, 16'h0000);
    check("rst flags", flags_out, 8'h00);
    reset_n = 1'b1;

    // flag byte bits: C=80 Z=40 S=20 V=10 D=08 H=04
    run_op("ADD",  OP_ADD, 16'h00FF, 16'h0001, 8'h00, 16'h0100, 8'h04);
    run_op("SUB",  OP_SUB, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 8'h1C);
    run_op("SBC",  OP_SBC, 16'h0000, 16'h0000, 8'h80, 16'hFFFF, 8'hAC);
    run_op("RRC",  OP_RRC, 16'h0001, 16'h0000, 8'h80, 16'h8000, 8'hB0);
    run_op("INC",  OP_INC, 16'hFFFF, 16'h0000, 8'h80, 16'h0000, 8'hC0);
    run_op("CP",   OP_CP,  16'h1234, 16'h1234, 8'h00, 16'h1234, 8'h48);
    run_op("AND",  OP_AND, 16'hF0F0, 16'h0FF0, 8'h8F, 16'h00F0, 8'h8F);
    run_op("CLR",  OP_CLR, 16'h5555, 16'h0000, 8'h5A, 16'h0000, 8'h5A);
    run_op("RL",   OP_RL,  16'h8001, 16'h0000, 8'h00, 16'h0003, 8'h90);
    run_op("SRA",  OP_SRA, 16'h8002, 16'h0000, 8'h00, 16'hC001, 8'h20);
    run_op("DEC",  OP_DEC, 16'h8000, 16'h0000, 8'h00, 16'h7FFF, 8'h10);
    run_op("RSVD", 5'd25,  16'hBEEF, 16'h1111, 8'h33, 16'hBEEF, 8'h33);
    run_op("BCDADD", OP_ADD, 16'h0019, 16'h0028, 8'h00, 16'h0041, 8'h04);
`ifdef ALU_WORD_SEQ_DA_EN
    run_op("DA",   OP_DA,  16'h0041, 16'h0000, 8'h04, 16'h0047, 8'h04);
`else
    run_op("DA",   OP_DA,  16'h0041, 16'h0000, 8'h04, 16'h0041, 8'h04);
`endif

    // Back-pressure: result held while res_ready is low; new commands ignored.
    begin
      int lat;
      issue(OP_ADD, 16'h0001, 16'h0002, 8'h00);
      lat = 0;
      while (!res_valid && lat < 10) begin
        @(posedge clk);
        #1;
        lat++;
      end
      check("hold latency", lat, 2);
      for (int i = 0; i < 5; i++) begin
        cmd_valid = 1'b1;
        op        = OP_SUB;
        a         = 16'h7777;
        b         = 16'h1111;
        @(posedge clk);
        #1;
        check("hold result", result, 16'h0003);
        check("hold flags", flags_out, 8'h00);
        check("hold cmd_ready", cmd_ready, 1'b0);
        check("hold res_valid", res_valid, 1'b1);
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      check("release res_valid", res_valid, 1'b0);
      check("release cmd_ready", cmd_ready, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      check("ignored cmd busy", busy, 1'b0);
      check("ignored cmd res_valid", res_valid, 1'b0);
    end

    // Reset during the first RUN cycle discards the op.
    issue(OP_ADD, 16'h1234, 16'h1111, 8'h00);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst res_valid", res_valid, 1'b0);
    check("midrst cmd_ready", cmd_ready, 1'b1);
    check("midrst busy", busy, 1'b0);
    check("midrst result", result, 16'h0000);
    @(posedge clk);
    #1;
    check("midrst held res_valid", res_valid, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("ADD after rst", OP_ADD, 16'h0001, 16'h0001, 8'h00, 16'h0002, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
